serial_io_controller: RTL and testbench
=======================================

// Module: serial_io_controller
// PURPOSE
//  Sequences the serial port on behalf of the processor's memory-mapped I/O window; sits between data_memory and the serial device.
//  Buffers outbound bytes (TX FIFO) and inbound bytes (RX FIFO), runs both device handshakes and exposes DATA/STATUS registers.
//  Lets a single-cycle CPU issue I/O loads/stores without stalling on device readiness.
// PARAMETERS
//  DEPTH   8  entries per FIFO (TX and RX); power of two, 2..128
//  PTR_W   3  log2(DEPTH); FIFO pointer width
// PORTS
//  clock            in   1   rising-edge clock
//  reset            in   1   asynchronous, active-high reset
//  addr_in          in   1   register select: 0 = DATA, 1 = STATUS
//  re_in            in   1   CPU read strobe (one cycle per access)
//  we_in            in   1   CPU write strobe (one cycle per access)
//  writedata_in     in   8   CPU write byte
//  readdata_out     out  32  CPU read data; combinational from current state
//  serial_in        in   8   inbound byte from device
//  serial_valid_in  in   1   device has inbound byte on serial_in
//  serial_rden_out  out  1   one-cycle acknowledge of inbound byte
//  serial_ready_in  in   1   device can accept an outbound byte
//  serial_out       out  8   outbound byte, registered
//  serial_wren_out  out  1   one-cycle strobe qualifying serial_out
// BEHAVIOUR
//  Reset (async): both FIFOs empty, sticky flags 0, FSMs in IDLE; serial_rden_out=0, serial_wren_out=0, serial_out=8'h00.
//  CPU DATA read: readdata_out={24'b0, RX head}; RX pops on the clock edge where re_in=1.
//   - If RX is empty: returns 0, no pop, sets sticky rx_underflow.
//  CPU DATA write: pushes writedata_in into TX on the edge.
//   - If TX is full at cycle start: byte dropped, sticky tx_overflow set. No pop-then-push bypass in the same cycle.
//  CPU STATUS read: readdata_out = {8'b0, tx_count[7:0], rx_count[7:0], 2'b0, rx_underflow, tx_overflow, tx_full, tx_empty, rx_full, rx_empty}.
//  CPU STATUS write: any value clears both sticky flags.
//  re_in and we_in both high: the read is served and the write is performed, both on the same edge.
//  RX FSM:
//   - IDLE -> ACK when serial_valid_in=1 and RX not full; serial_in is pushed on that edge.
//   - ACK: serial_rden_out=1 for exactly one cycle, then -> IDLE.
//   - RX full: stays IDLE, no ack; the device holds its byte.
//   - Max rate: 1 byte per 2 cycles.
//   - A CPU pop in the same edge as an RX push is legal; the count is unchanged.
//  TX FSM:
//   - IDLE -> SEND when TX not empty and serial_ready_in=1; the head is registered to serial_out and popped on that edge.
//   - SEND: serial_wren_out=1 for one cycle, then -> IDLE.
//   - serial_out holds its last value otherwise.
//   - Max rate: 1 byte per 2 cycles. A CPU push in the same edge as a TX pop is legal.
//  FIFOs: PTR_W-bit wrapping pointers plus a (PTR_W+1)-bit count; full when count==DEPTH, empty when count==0; order is strictly FIFO.
//  Reset mid-transfer: in-flight strobes drop immediately; buffered bytes are discarded.
// TESTING
//  1. Reset, then read STATUS -> 32'h0000_0005 (rx_empty=1, tx_empty=1); all serial outputs 0.
//  2. Write 8'h41 to DATA with serial_ready_in=1 -> 2 cycles later serial_out=8'h41 with serial_wren_out high for 1 cycle; STATUS tx_empty=1.
//  3. Hold serial_ready_in=0 and write 9 bytes (DEPTH=8) -> tx_full=1, tx_overflow=1, tx_count=8.
//     Then raise ready -> exactly the first 8 bytes appear in order. A STATUS write then clears the flag.
//  4. Device presents 8'h5A with serial_valid_in -> serial_rden_out pulses once; STATUS rx_count=1.
//     DATA read -> 32'h0000_005A; STATUS then shows rx_empty=1.
//  5. DATA read with RX empty -> returns 0 and sets rx_underflow (STATUS bit5); the count stays 0.
//     Fill RX to 8 with valid held high -> no further rden until the CPU pops one.
//  6. Assert reset mid-SEND and mid-ACK -> strobes drop the same cycle; after release STATUS=32'h0000_0005.

Source files
------------

// File: rtl/serial_io_controller.sv
// Serial I/O controller: memory-mapped DATA/STATUS registers in front of a serial device.
// Outbound bytes queue in a TX FIFO and inbound bytes in an RX FIFO, so a single-cycle CPU
// never stalls on device readiness. Each device handshake is a small two-state FSM.

module serial_io_controller #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned PTR_W = 3
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        addr_in,
  input  logic        re_in,
  input  logic        we_in,
  input  logic [7:0]  writedata_in,
  output logic [31:0] readdata_out,
  input  logic [7:0]  serial_in,
  input  logic        serial_valid_in,
  output logic        serial_rden_out,
  input  logic        serial_ready_in,
  output logic [7:0]  serial_out,
  output logic        serial_wren_out
);

  localparam logic [PTR_W:0]   CntFull = (PTR_W + 1)'(DEPTH);
  localparam logic [PTR_W:0]   CntOne  = (PTR_W + 1)'(1);
  localparam logic [PTR_W-1:0] PtrOne  = PTR_W'(1);

  typedef enum logic {RxIdle, RxAck} rx_state_e;
  typedef enum logic {TxIdle, TxSend} tx_state_e;

  // FIFO storage and bookkeeping
  logic [7:0]       rx_mem_q [DEPTH];
  logic [7:0]       tx_mem_q [DEPTH];
  logic [PTR_W-1:0] rx_wr_ptr_q, rx_rd_ptr_q;
  logic [PTR_W-1:0] tx_wr_ptr_q, tx_rd_ptr_q;
  logic [PTR_W:0]   rx_count_q, rx_count_d;
  logic [PTR_W:0]   tx_count_q, tx_count_d;

  logic rx_underflow_q, tx_overflow_q;

  rx_state_e rx_state_q, rx_state_d;
  tx_state_e tx_state_q, tx_state_d;

  logic rx_empty, rx_full, tx_empty, tx_full;
  logic data_rd, data_wr, status_wr;
  logic cpu_pop, cpu_push;
  logic rx_push, tx_pop;
  logic [7:0] rx_count8, tx_count8;

  assign rx_empty = (rx_count_q == '0);
  assign rx_full  = (rx_count_q == CntFull);
  assign tx_empty = (tx_count_q == '0);
  assign tx_full  = (tx_count_q == CntFull);

  assign data_rd   = re_in & ~addr_in;
  assign data_wr   = we_in & ~addr_in;
  assign status_wr = we_in & addr_in;

  // Fullness/emptiness is judged on the state at cycle start: no same-cycle bypass.
  assign cpu_pop  = data_rd & ~rx_empty;
  assign cpu_push = data_wr & ~tx_full;

  assign rx_count8 = 8'(rx_count_q);
  assign tx_count8 = 8'(tx_count_q);

  // RX handshake: accept a byte when there is room, then acknowledge it for one cycle
  always_comb begin
    rx_state_d      = rx_state_q;
    rx_push         = 1'b0;
    serial_rden_out = 1'b0;
    case (rx_state_q)
      RxIdle: begin
        if (serial_valid_in && !rx_full) begin
          rx_push    = 1'b1;
          rx_state_d = RxAck;
        end
      end
      RxAck: begin
        serial_rden_out = 1'b1;
        rx_state_d      = RxIdle;
      end
    endcase
  end

  // TX handshake: launch the FIFO head when the device is ready, then strobe for one cycle
  always_comb begin
    tx_state_d      = tx_state_q;
    tx_pop          = 1'b0;
    serial_wren_out = 1'b0;
    case (tx_state_q)
      TxIdle: begin
        if (!tx_empty && serial_ready_in) begin
          tx_pop     = 1'b1;
          tx_state_d = TxSend;
        end
      end
      TxSend: begin
        serial_wren_out = 1'b1;
        tx_state_d      = TxIdle;
      end
    endcase
  end

  // Occupancy next-state: a simultaneous push and pop leaves the count unchanged
  always_comb begin
    rx_count_d = rx_count_q;
    case ({rx_push, cpu_pop})
      2'b10:   rx_count_d = rx_count_q + CntOne;
      2'b01:   rx_count_d = rx_count_q - CntOne;
      default: rx_count_d = rx_count_q;
    endcase
    tx_count_d = tx_count_q;
    case ({cpu_push, tx_pop})
      2'b10:   tx_count_d = tx_count_q + CntOne;
      2'b01:   tx_count_d = tx_count_q - CntOne;
      default: tx_count_d = tx_count_q;
    endcase
  end

  // FSM state registers
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rx_state_q <= RxIdle;
      tx_state_q <= TxIdle;
    end else begin
      rx_state_q <= rx_state_d;
      tx_state_q <= tx_state_d;
    end
  end

  // FIFO pointers and counts; reset discards any buffered bytes
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rx_wr_ptr_q <= '0;
      rx_rd_ptr_q <= '0;
      rx_count_q  <= '0;
      tx_wr_ptr_q <= '0;
      tx_rd_ptr_q <= '0;
      tx_count_q  <= '0;
    end else begin
      if (rx_push)  rx_wr_ptr_q <= rx_wr_ptr_q + PtrOne;
      if (cpu_pop)  rx_rd_ptr_q <= rx_rd_ptr_q + PtrOne;
      if (cpu_push) tx_wr_ptr_q <= tx_wr_ptr_q + PtrOne;
      if (tx_pop)   tx_rd_ptr_q <= tx_rd_ptr_q + PtrOne;
      rx_count_q <= rx_count_d;
      tx_count_q <= tx_count_d;
    end
  end

  // FIFO data arrays; contents are don't-care until the pointers say otherwise
  always_ff @(posedge clock) begin
    if (rx_push)  rx_mem_q[rx_wr_ptr_q] <= serial_in;
    if (cpu_push) tx_mem_q[tx_wr_ptr_q] <= writedata_in;
  end

  // Sticky error flags, cleared by any STATUS write
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rx_underflow_q <= 1'b0;
      tx_overflow_q  <= 1'b0;
    end else if (status_wr) begin
      rx_underflow_q <= 1'b0;
      tx_overflow_q  <= 1'b0;
    end else begin
      if (data_rd && rx_empty) rx_underflow_q <= 1'b1;
      if (data_wr && tx_full)  tx_overflow_q  <= 1'b1;
    end
  end

  // Outbound byte register; holds its last value between transfers
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      serial_out <= 8'h00;
    end else if (tx_pop) begin
      serial_out <= tx_mem_q[tx_rd_ptr_q];
    end
  end

  // CPU read mux; an empty RX reads as zero
  always_comb begin
    readdata_out = 32'h0000_0000;
    if (addr_in) begin
      readdata_out = {8'h00, tx_count8, rx_count8, 2'b00, rx_underflow_q, tx_overflow_q,
                      tx_full, tx_empty, rx_full, rx_empty};
    end else if (!rx_empty) begin
      readdata_out = {24'h00_0000, rx_mem_q[rx_rd_ptr_q]};
    end
  end

endmodule

// File: tb/tb_serial_io_controller.sv
// Self-checking bench for serial_io_controller: directed scenarios plus randomized traffic
// scored against queue-based models of the device and both FIFOs.

module tb_serial_io_controller;

  localparam int DEPTH = 8;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        addr_in = 1'b0;
  logic        re_in = 1'b0;
  logic        we_in = 1'b0;
  logic [7:0]  writedata_in = 8'h00;
  logic [31:0] readdata_out;
  logic [7:0]  serial_in = 8'h00;
  logic        serial_valid_in = 1'b0;
  logic        serial_rden_out;
  logic        serial_ready_in = 1'b0;
  logic [7:0]  serial_out;
  logic        serial_wren_out;

  int compared = 0;
  int mismatched = 0;

  logic [7:0] dev_q[$];     // bytes the device still wants to deliver
  logic [7:0] rx_model[$];  // bytes acknowledged by the DUT and not yet read by the CPU
  logic [7:0] tx_seen[$];   // bytes the device has received
  bit         dev_en = 1'b0;
  int         rden_pulses = 0;
  logic       prev_wren = 1'b0;
  logic       prev_rden = 1'b0;

  serial_io_controller #(.DEPTH(8), .PTR_W(3)) dut (
    .clock           (clock),
    .reset           (reset),
    .addr_in         (addr_in),
    .re_in           (re_in),
    .we_in           (we_in),
    .writedata_in    (writedata_in),
    .readdata_out    (readdata_out),
    .serial_in       (serial_in),
    .serial_valid_in (serial_valid_in),
    .serial_rden_out (serial_rden_out),
    .serial_ready_in (serial_ready_in),
    .serial_out      (serial_out),
    .serial_wren_out (serial_wren_out)
  );

  always #5 clock = ~clock;

  // Device model: observes strobes on the falling edge and presents the next inbound byte
  always @(negedge clock) begin
    if (reset) begin
      prev_wren = 1'b0;
      prev_rden = 1'b0;
    end else begin
      if (serial_wren_out) begin
        compared++;
        if (prev_wren) begin
          mismatched++;
          $display("FAIL wren_pulse: strobe high %0d cycles in a row, required 1", 2);
        end
        tx_seen.push_back(serial_out);
      end
      if (serial_rden_out) begin
        compared++;
        if (prev_rden || dev_q.size() == 0) begin
          mismatched++;
          $display("FAIL rden_pulse: prev=%0b pending=%0d, required prev=0 pending>0",
                   prev_rden, dev_q.size());
        end else begin
          rx_model.push_back(dev_q.pop_front());
        end
        rden_pulses++;
      end
      prev_wren = serial_wren_out;
      prev_rden = serial_rden_out;
    end
    serial_valid_in = dev_en && (dev_q.size() > 0);
    serial_in       = (dev_q.size() > 0) ? dev_q[0] : 8'h00;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] status_word(input int txc, input int rxc,
                                              input logic rxu, input logic txo);
    logic [7:0] t8;
    logic [7:0] r8;
    t8 = txc[7:0];
    r8 = rxc[7:0];
    return {8'h00, t8, r8, 2'b00, rxu, txo, txc == DEPTH, txc == 0, rxc == DEPTH, rxc == 0};
  endfunction

  // One CPU access, started and finished on a falling edge; read data sampled mid-cycle.
  task automatic cpu_access(input logic a, input logic rd, input logic wr, input logic [7:0] wd,
                            output logic [31:0] rdata);
    addr_in      = a;
    re_in        = rd;
    we_in        = wr;
    writedata_in = wd;
    #1 rdata = readdata_out;
    @(negedge clock);
    re_in = 1'b0;
    we_in = 1'b0;
  endtask

  task automatic cpu_write(input logic a, input logic [7:0] wd);
    logic [31:0] dummy;
    cpu_access(a, 1'b0, 1'b1, wd, dummy);
  endtask

  task automatic cpu_read(input logic a, output logic [31:0] rdata);
    cpu_access(a, 1'b1, 1'b0, 8'h00, rdata);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic do_reset();
    reset  = 1'b1;
    dev_en = 1'b0;
    dev_q.delete();
    serial_ready_in = 1'b0;
    idle(2);
    reset = 1'b0;
    rx_model.delete();
    tx_seen.delete();
  endtask

  task automatic test_reset();
    logic [31:0] d;
    do_reset();
    compared++;
    if (serial_rden_out !== 1'b0 || serial_wren_out !== 1'b0 || serial_out !== 8'h00) begin
      mismatched++;
      $display("FAIL reset_outputs: rden=%0b wren=%0b out=%h, required 0 0 00",
               serial_rden_out, serial_wren_out, serial_out);
    end
    cpu_read(1'b1, d);
    compared++;
    if (d !== 32'h0000_0005) begin
      mismatched++;
      $display("FAIL reset_status: got %h, required %h", d, 32'h0000_0005);
    end
  endtask

  task automatic test_tx_single();
    logic [31:0] d;
    serial_ready_in = 1'b1;
    cpu_write(1'b0, 8'h41);
    compared++;
    if (serial_wren_out !== 1'b0) begin
      mismatched++;
      $display("FAIL tx_single_early: wren=%0b, required 0", serial_wren_out);
    end
    idle(1);
    compared++;
    if (serial_wren_out !== 1'b1 || serial_out !== 8'h41) begin
      mismatched++;
      $display("FAIL tx_single_send: wren=%0b out=%h, required 1 41", serial_wren_out, serial_out);
    end
    idle(1);
    compared++;
    if (serial_wren_out !== 1'b0 || serial_out !== 8'h41) begin
      mismatched++;
      $display("FAIL tx_single_after: wren=%0b out=%h, required 0 41", serial_wren_out, serial_out);
    end
    cpu_read(1'b1, d);
    compared++;
    if (d !== status_word(0, 0, 1'b0, 1'b0)) begin
      mismatched++;
      $display("FAIL tx_single_status: got %h, required %h", d, status_word(0, 0, 1'b0, 1'b0));
    end
    compared++;
    if (tx_seen.size() != 1) begin
      mismatched++;
      $display("FAIL tx_single_count: got %0d bytes, required 1", tx_seen.size());
    end
    tx_seen.delete();
  endtask

  task automatic test_tx_overflow();
    logic [31:0] d;
    logic [7:0]  sent[$];
    logic [7:0]  v;
    serial_ready_in = 1'b0;
    for (int i = 0; i < DEPTH + 1; i++) begin
      v = 8'($urandom);
      sent.push_back(v);
      cpu_write(1'b0, v);
    end
    cpu_read(1'b1, d);
    compared++;
    if (d !== status_word(DEPTH, 0, 1'b0, 1'b1)) begin
      mismatched++;
      $display("FAIL tx_overflow_status: got %h, required %h", d,
               status_word(DEPTH, 0, 1'b0, 1'b1));
    end
    serial_ready_in = 1'b1;
    for (int i = 0; i < 40 && tx_seen.size() < DEPTH; i++) idle(1);
    idle(6);
    compared++;
    if (tx_seen.size() != DEPTH) begin
      mismatched++;
      $display("FAIL tx_overflow_drain: got %0d bytes, required %0d", tx_seen.size(), DEPTH);
    end
    for (int i = 0; i < DEPTH && i < tx_seen.size(); i++) begin
      compared++;
      if (tx_seen[i] !== sent[i]) begin
        mismatched++;
        $display("FAIL tx_overflow_order[%0d]: got %h, required %h", i, tx_seen[i], sent[i]);
      end
    end
    cpu_read(1'b1, d);
    compared++;
    if (d !== status_word(0, 0, 1'b0, 1'b1)) begin
      mismatched++;
      $display("FAIL tx_overflow_sticky: got %h, required %h", d, status_word(0, 0, 1'b0, 1'b1));
    end
    cpu_write(1'b1, 8'($urandom));
    cpu_read(1'b1, d);
    compared++;
    if (d !== status_word(0, 0, 1'b0, 1'b0)) begin
      mismatched++;
      $display("FAIL tx_overflow_clear: got %h, required %h", d, status_word(0, 0, 1'b0, 1'b0));
    end
    tx_seen.delete();
  endtask

  task automatic test_rx_single();
    logic [31:0] d;
    int          start;
    start = rden_pulses;
    dev_q.push_back(8'h5A);
    dev_en = 1'b1;
    for (int i = 0; i < 10 && rden_pulses == start; i++) idle(1);
    idle(4);
    compared++;
    if (rden_pulses - start != 1) begin
      mismatched++;
      $display("FAIL rx_single_acks: got %0d, required 1", rden_pulses - start);
    end
    cpu_read(1'b1, d);
    compared++;
    if (d !== status_word(0, 1, 1'b0, 1'b0)) begin
      mismatched++;
      $display("FAIL rx_single_status: got %h, required %h", d, status_word(0, 1, 1'b0, 1'b0));
    end
    cpu_read(1'b0, d);
    compared++;
    if (d !== 32'h0000_005A) begin
      mismatched++;
      $display("FAIL rx_single_data: got %h, required %h", d, 32'h0000_005A);
    end
    cpu_read(1'b1, d);
    compared++;
    if (d !== status_word(0, 0, 1'b0, 1'b0)) begin
      mismatched++;
      $display("FAIL rx_single_empty: got %h, required %h", d, status_word(0, 0, 1'b0, 1'b0));
    end
    dev_en = 1'b0;
    rx_model.delete();
  endtask

  task automatic test_rx_underflow_full();
    logic [31:0] d;
    logic [7:0]  bytes[$];
    int          start;
    cpu_read(1'b0, d);
    compared++;
    if (d !== 32'h0) begin
      mismatched++;
      $display("FAIL rx_underflow_data: got %h, required 0", d);
    end
    cpu_read(1'b1, d);
    compared++;
    if (d !== status_word(0, 0, 1'b1, 1'b0)) begin
      mismatched++;
      $display("FAIL rx_underflow_status: got %h, required %h", d, status_word(0, 0, 1'b1, 1'b0));
    end
    start = rden_pulses;
    for (int i = 0; i < DEPTH + 2; i++) begin
      bytes.push_back(8'($urandom));
      dev_q.push_back(bytes[i]);
    end
    dev_en = 1'b1;
    idle(30);
    compared++;
    if (rden_pulses - start != DEPTH) begin
      mismatched++;
      $display("FAIL rx_full_acks: got %0d, required %0d", rden_pulses - start, DEPTH);
    end
    cpu_read(1'b1, d);
    compared++;
    if (d !== status_word(0, DEPTH, 1'b1, 1'b0)) begin
      mismatched++;
      $display("FAIL rx_full_status: got %h, required %h", d, status_word(0, DEPTH, 1'b1, 1'b0));
    end
    cpu_read(1'b0, d);
    compared++;
    if (d !== {24'h0, bytes[0]}) begin
      mismatched++;
      $display("FAIL rx_full_first: got %h, required %h", d, {24'h0, bytes[0]});
    end
    idle(6);
    compared++;
    if (rden_pulses - start != DEPTH + 1) begin
      mismatched++;
      $display("FAIL rx_full_resume: got %0d acks, required %0d", rden_pulses - start, DEPTH + 1);
    end
    for (int i = 1; i < DEPTH + 2; i++) begin
      cpu_read(1'b0, d);
      compared++;
      if (d !== {24'h0, bytes[i]}) begin
        mismatched++;
        $display("FAIL rx_full_order[%0d]: got %h, required %h", i, d, {24'h0, bytes[i]});
      end
    end
    dev_en = 1'b0;
    rx_model.delete();
    cpu_write(1'b1, 8'h00);
  endtask

  task automatic test_reset_mid_transfer();
    logic [31:0] d;
    bit          seen;
    serial_ready_in = 1'b0;
    for (int i = 0; i < 3; i++) cpu_write(1'b0, 8'($urandom_range(1, 255)));
    serial_ready_in = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      idle(1);
      seen = serial_wren_out;
    end
    compared++;
    if (!seen) begin
      mismatched++;
      $display("FAIL mid_send_timeout: wren=%0b, required 1 within 10 cycles", serial_wren_out);
    end
    #1 reset = 1'b1;
    #1;
    compared++;
    if (serial_wren_out !== 1'b0 || serial_out !== 8'h00) begin
      mismatched++;
      $display("FAIL mid_send_drop: wren=%0b out=%h, required 0 00", serial_wren_out, serial_out);
    end
    @(negedge clock);
    reset = 1'b0;
    tx_seen.delete();
    idle(8);
    compared++;
    if (tx_seen.size() != 0) begin
      mismatched++;
      $display("FAIL mid_send_discard: got %0d bytes sent, required 0", tx_seen.size());
    end
    dev_q.push_back(8'h3C);
    dev_q.push_back(8'hC3);
    dev_en = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      idle(1);
      seen = serial_rden_out;
    end
    compared++;
    if (!seen) begin
      mismatched++;
      $display("FAIL mid_ack_timeout: rden=%0b, required 1 within 10 cycles", serial_rden_out);
    end
    #1 reset = 1'b1;
    dev_en = 1'b0;
    dev_q.delete();
    #1;
    compared++;
    if (serial_rden_out !== 1'b0) begin
      mismatched++;
      $display("FAIL mid_ack_drop: rden=%0b, required 0", serial_rden_out);
    end
    @(negedge clock);
    reset = 1'b0;
    rx_model.delete();
    cpu_read(1'b1, d);
    compared++;
    if (d !== 32'h0000_0005) begin
      mismatched++;
      $display("FAIL mid_reset_status: got %h, required %h", d, 32'h0000_0005);
    end
  endtask

  task automatic test_tx_random();
    logic [31:0] d;
    logic [7:0]  exp[$];
    logic [7:0]  v;
    int          n;
    for (int b = 0; b < 4; b++) begin
      exp.delete();
      tx_seen.delete();
      n = $urandom_range(1, DEPTH);
      for (int k = 0; k < n; k++) begin
        serial_ready_in = 1'($urandom_range(0, 1));
        v = 8'($urandom);
        exp.push_back(v);
        cpu_write(1'b0, v);
        for (int g = $urandom_range(0, 2); g > 0; g--) begin
          serial_ready_in = 1'($urandom_range(0, 1));
          idle(1);
        end
      end
      serial_ready_in = 1'b1;
      for (int i = 0; i < 40 && tx_seen.size() < n; i++) idle(1);
      idle(3);
      compared++;
      if (tx_seen.size() != n) begin
        mismatched++;
        $display("FAIL tx_random_count[%0d]: got %0d, required %0d", b, tx_seen.size(), n);
      end
      for (int i = 0; i < n && i < tx_seen.size(); i++) begin
        compared++;
        if (tx_seen[i] !== exp[i]) begin
          mismatched++;
          $display("FAIL tx_random_byte[%0d][%0d]: got %h, required %h", b, i, tx_seen[i], exp[i]);
        end
      end
    end
    cpu_read(1'b1, d);
    compared++;
    if (d !== status_word(0, 0, 1'b0, 1'b0)) begin
      mismatched++;
      $display("FAIL tx_random_status: got %h, required %h", d, status_word(0, 0, 1'b0, 1'b0));
    end
    tx_seen.delete();
  endtask

  task automatic test_rx_random();
    logic [31:0] d;
    logic [31:0] e;
    logic        exp_rxu;
    int          r;
    int          budget;
    rx_model.delete();
    exp_rxu = 1'b0;
    for (int i = 0; i < 20; i++) dev_q.push_back(8'($urandom));
    dev_en = 1'b1;
    budget = 0;
    for (int c = 0; c < 80 || ((dev_q.size() > 0 || rx_model.size() > 0) && budget < 120); c++) begin
      if (c >= 80) budget++;
      r = (c >= 80) ? 0 : $urandom_range(0, 3);
      if (r <= 1) begin
        addr_in = 1'b0;
        re_in   = 1'b1;
        #1 d = readdata_out;
        if (rx_model.size() > 0) begin
          e = {24'h0, rx_model.pop_front()};
        end else begin
          e = 32'h0;
          exp_rxu = 1'b1;
        end
        @(negedge clock);
        re_in = 1'b0;
        compared++;
        if (d !== e) begin
          mismatched++;
          $display("FAIL rx_random_data[%0d]: got %h, required %h", c, d, e);
        end
      end else if (r == 2) begin
        addr_in = 1'b1;
        re_in   = 1'b1;
        #1 d = readdata_out;
        e = status_word(0, rx_model.size(), exp_rxu, 1'b0);
        @(negedge clock);
        re_in = 1'b0;
        compared++;
        if (d !== e) begin
          mismatched++;
          $display("FAIL rx_random_status[%0d]: got %h, required %h", c, d, e);
        end
      end else begin
        idle(1);
      end
    end
    compared++;
    if (dev_q.size() != 0 || rx_model.size() != 0) begin
      mismatched++;
      $display("FAIL rx_random_drain: pending=%0d buffered=%0d, required 0 0",
               dev_q.size(), rx_model.size());
    end
    dev_en = 1'b0;
    cpu_write(1'b1, 8'h00);
  endtask

  task automatic test_back_to_back();
    logic [31:0] d;
    serial_ready_in = 1'b0;
    rx_model.delete();
    dev_q.push_back(8'hC3);
    dev_en = 1'b1;
    for (int i = 0; i < 10 && rx_model.size() == 0; i++) idle(1);
    idle(1);
    dev_en = 1'b0;
    rx_model.delete();
    cpu_access(1'b0, 1'b1, 1'b1, 8'h77, d);
    compared++;
    if (d !== 32'h0000_00C3) begin
      mismatched++;
      $display("FAIL rdwr_data_read: got %h, required %h", d, 32'h0000_00C3);
    end
    cpu_read(1'b1, d);
    compared++;
    if (d !== status_word(1, 0, 1'b0, 1'b0)) begin
      mismatched++;
      $display("FAIL rdwr_data_status: got %h, required %h", d, status_word(1, 0, 1'b0, 1'b0));
    end
    tx_seen.delete();
    serial_ready_in = 1'b1;
    for (int i = 0; i < 10 && tx_seen.size() == 0; i++) idle(1);
    compared++;
    if (tx_seen.size() != 1 || tx_seen[0] !== 8'h77) begin
      mismatched++;
      $display("FAIL rdwr_data_send: got %0d bytes first=%h, required 1 77", tx_seen.size(),
               (tx_seen.size() > 0) ? tx_seen[0] : 8'h00);
    end
    tx_seen.delete();
    serial_ready_in = 1'b0;
    cpu_read(1'b0, d);
    cpu_access(1'b1, 1'b1, 1'b1, 8'hFF, d);
    compared++;
    if (d !== status_word(0, 0, 1'b1, 1'b0)) begin
      mismatched++;
      $display("FAIL rdwr_status_read: got %h, required %h", d, status_word(0, 0, 1'b1, 1'b0));
    end
    cpu_read(1'b1, d);
    compared++;
    if (d !== 32'h0000_0005) begin
      mismatched++;
      $display("FAIL rdwr_status_clear: got %h, required %h", d, 32'h0000_0005);
    end
  endtask

  initial begin
    @(negedge clock);
    test_reset();
    test_tx_single();
    test_tx_overflow();
    test_rx_single();
    test_rx_underflow_full();
    test_reset_mid_transfer();
    test_tx_random();
    test_rx_random();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
